mul_radix4_booth_seq: RTL and testbench

- Iterative, parametrised radix-4 Booth multiplier. It retires one Booth digit per clock into an internal accumulator.
- Supports signed and unsigned operands, selected per transaction.
- Uses a valid/ready handshake on both input and output.
- Sits in the calc/mul library as the area-optimised successor to the single-digit combinational Booth partial-product stage, and reuses that stage as its per-cycle datapath.

---
 rtl/mul_pkg.sv | 33 +++
 rtl/mul_radix4_booth_pp.sv | 38 +++
 rtl/mul_radix4_booth_seq.sv | 129 ++++++++++++
 tb/tb_mul_radix4_booth_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the calc/mul library: Booth digit
// operations, multiplier FSM states and the digit decoder.
package mul_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_POS1,
    BOOTH_POS2,
    BOOTH_NEG2,
    BOOTH_NEG1
  } booth_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_e;

  function automatic booth_op_e booth_decode(
    input logic [2:0] d
  );
    booth_op_e op;
    unique case (d)
      3'b001, 3'b010: op = BOOTH_POS1;
      3'b011:         op = BOOTH_POS2;
      3'b100:         op = BOOTH_NEG2;
      3'b101, 3'b110: op = BOOTH_NEG1;
      default:        op = BOOTH_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_radix4_booth_pp.sv
// Single radix-4 Booth digit partial product: sign-extended
// selection of 0/+-X/+-2X; negation completes via o_cin.
module mul_radix4_booth_pp
  import mul_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0]   i_x,
  input  logic [2:0]         i_digit,
  output logic [2*WIDTH-1:0] o_pp,
  output logic               o_cin
);

  logic [2*WIDTH-1:0] x1;
  logic [2*WIDTH-1:0] x2;

  assign x1 = {{WIDTH{i_x[WIDTH-1]}}, i_x};
  assign x2 = {x1[2*WIDTH-2:0], 1'b0};

  always_comb begin
    o_pp  = '0;
    o_cin = 1'b0;
    unique case (booth_decode(i_digit))
      BOOTH_POS1: o_pp = x1;
      BOOTH_POS2: o_pp = x2;
      BOOTH_NEG1: begin
        o_pp  = ~x1;
        o_cin = 1'b1;
      end
      BOOTH_NEG2: begin
        o_pp  = ~x2;
        o_cin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_radix4_booth_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock,
// signed/unsigned per transaction, valid/ready on both sides.
module mul_radix4_booth_seq
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_vld,
  output logic                    o_rdy,
  input  logic                    i_sign,
  input  logic [DATA_WIDTH-1:0]   i_num_x,
  input  logic [DATA_WIDTH-1:0]   i_num_y,
  output logic                    o_vld,
  input  logic                    i_rdy,
  output logic [2*DATA_WIDTH-1:0] o_res,
  output logic                    o_busy
);

  localparam int W  = DATA_WIDTH + 2;
  localparam int N  = W / 2;
  localparam int CW = $clog2(N);
  localparam int AW = 2 * W;
  localparam int RW = 2 * DATA_WIDTH;

  if (DATA_WIDTH % 2 != 0 || DATA_WIDTH < 4) begin : g_bad_width
    $error("DATA_WIDTH must be even and >= 4");
  end

  mul_state_e    state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [RW-1:0] res_q, res_d;

  logic [W:0]    y_ext;
  logic [CW:0]   shamt;
  logic [2:0]    digit;
  logic [AW-1:0] pp;
  logic          cin;
  logic [AW-1:0] pp_sh;
  logic [AW-1:0] cin_sh;
  logic          last;
  logic [1:0]    fill_x;
  logic [1:0]    fill_y;

  // y[-1] = 0 sits below the operand so digit k is y_ext[2k +: 3]
  assign y_ext  = {y_q, 1'b0};
  assign shamt  = {cnt_q, 1'b0};
  assign digit  = y_ext[shamt +: 3];
  assign last   = (cnt_q == CW'(N - 1));
  assign fill_x = {2{i_sign & i_num_x[DATA_WIDTH-1]}};
  assign fill_y = {2{i_sign & i_num_y[DATA_WIDTH-1]}};

  mul_radix4_booth_pp #(
    .WIDTH (W)
  ) u_pp (
    .i_x     (x_q),
    .i_digit (digit),
    .o_pp    (pp),
    .o_cin   (cin)
  );

  assign pp_sh  = pp << shamt;
  assign cin_sh = AW'(cin) << shamt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_vld) state_d = CALC;
      CALC:    if (last)  state_d = DONE;
      DONE:    if (i_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_rdy  = (state_q == IDLE);
    o_vld  = (state_q == DONE);
    o_busy = (state_q != IDLE);
    o_res  = res_q;
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    res_d = res_q;
    unique case (state_q)
      IDLE: if (i_vld) begin
        x_d   = {fill_x, i_num_x};
        y_d   = {fill_y, i_num_y};
        cnt_d = '0;
        acc_d = '0;
      end
      CALC: begin
        acc_d = acc_q + pp_sh + cin_sh;
        cnt_d = cnt_q + CW'(1);
        if (last) res_d = acc_d[RW-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_mul_radix4_booth_seq.sv
// Scoreboard bench: 8-bit directed corners plus 16-bit
// random pairs against an integer-arithmetic product model.
module tb_mul_radix4_booth_seq;

  localparam int N8  = 5;
  localparam int N16 = 9;

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic        vld8, sign8, rdy8, ordy8, ovld8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] res8;
  logic        vld16, sign16, rdy16, ordy16, ovld16, busy16;
  logic [15:0] x16, y16;
  logic [31:0] res16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  bit   seen8, seen16;

  mul_radix4_booth_seq #(.DATA_WIDTH(8)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld8), .o_rdy(ordy8),
    .i_sign(sign8), .i_num_x(x8), .i_num_y(y8), .o_vld(ovld8),
    .i_rdy(rdy8), .o_res(res8), .o_busy(busy8)
  );

  mul_radix4_booth_seq #(.DATA_WIDTH(16)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld16), .o_rdy(ordy16),
    .i_sign(sign16), .i_num_x(x16), .i_num_y(y16), .o_vld(ovld16),
    .i_rdy(rdy16), .o_res(res16), .o_busy(busy16)
  );

  function automatic logic [63:0] model(
    int dw, bit s, logic [31:0] x, logic [31:0] y
  );
    longint a, b, p;
    a = longint'(x);
    b = longint'(y);
    if (s && x[dw-1]) a -= longint'(1) << dw;
    if (s && y[dw-1]) b -= longint'(1) << dw;
    p = a * b;
    return 64'(p) & ((64'd1 << (2 * dw)) - 64'd1);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic flag(string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want completion", name);
  endtask

  always @(negedge clk) begin
    if (!rst_n) seen8 = 1'b0;
    else begin
      if (vld8 && ordy8) begin
        e8.exp = model(8, sign8, 32'(x8), 32'(y8));
        e8.acc = cyc + 1;
        q8.push_back(e8);
      end
      if (ovld8 && !seen8) begin
        seen8 = 1'b1;
        if (q8.size() == 0) flag("u8 unexpected o_vld");
        else begin
          check("u8 latency", 64'(cyc - q8[0].acc), 64'(N8));
          check("u8 res", 64'(res8), q8[0].exp);
        end
      end
      if (ovld8 && rdy8) begin
        if (q8.size() != 0) begin
          check("u8 res at handshake", 64'(res8), q8[0].exp);
          void'(q8.pop_front());
        end
        seen8 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) seen16 = 1'b0;
    else begin
      if (vld16 && ordy16) begin
        e16.exp = model(16, sign16, 32'(x16), 32'(y16));
        e16.acc = cyc + 1;
        q16.push_back(e16);
      end
      if (ovld16 && !seen16) begin
        seen16 = 1'b1;
        if (q16.size() == 0) flag("u16 unexpected o_vld");
        else begin
          check("u16 latency", 64'(cyc - q16[0].acc), 64'(N16));
          check("u16 res", 64'(res16), q16[0].exp);
        end
      end
      if (ovld16 && rdy16) begin
        if (q16.size() != 0) begin
          check("u16 res at handshake", 64'(res16), q16[0].exp);
          void'(q16.pop_front());
        end
        seen16 = 1'b0;
      end
    end
  end

  task automatic run8(bit s, logic [7:0] x, logic [7:0] y);
    int n;
    @(posedge clk); #1;
    sign8 = s; x8 = x; y8 = y; vld8 = 1'b1;
    n = 0;
    while (!ordy8 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ordy8) flag("u8 accept");
    @(posedge clk); #1;
    vld8 = 1'b0;
    x8 = 8'($urandom); y8 = 8'($urandom); sign8 = 1'($urandom);
    n = 0;
    while (q8.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (q8.size() != 0) begin
      flag("u8 drain");
      q8.delete();
    end
  endtask

  task automatic run16(bit s, logic [15:0] x, logic [15:0] y);
    int n;
    @(posedge clk); #1;
    sign16 = s; x16 = x; y16 = y; vld16 = 1'b1;
    n = 0;
    while (!ordy16 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ordy16) flag("u16 accept");
    @(posedge clk); #1;
    vld16 = 1'b0;
    x16 = 16'($urandom); y16 = 16'($urandom);
    n = 0;
    while (q16.size() != 0 && n < 100) begin
      rdy16 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1; n++;
    end
    rdy16 = 1'b1;
    if (q16.size() != 0) begin
      flag("u16 drain");
      q16.delete();
    end
  endtask

  bit          ds[7]   = '{0, 1, 1, 1, 0, 1, 0};
  logic [7:0]  dx[7]   = '{8'hFF, 8'h80, 8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'h00};
  logic [7:0]  dy[7]   = '{8'hFF, 8'h80, 8'h01, 8'h80, 8'h02, 8'h02, 8'hA5};
  logic [15:0] dexp[7] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'hC080,
                           16'h01FE, 16'hFFFE, 16'h0000};

  initial begin
    int n;
    vld8 = 0; sign8 = 0; x8 = 0; y8 = 0; rdy8 = 1;
    vld16 = 0; sign16 = 0; x16 = 0; y16 = 0; rdy16 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rdy", 64'(ordy8), 64'd1);
    check("reset vld", 64'(ovld8), 64'd0);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset res", 64'(res8), 64'd0);
    check("reset res16", 64'(res16), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run8(ds[i], dx[i], dy[i]);
      check("directed res", 64'(res8), 64'(dexp[i]));
    end

    // held backpressure with a competing request waiting
    @(posedge clk); #1;
    rdy8 = 0; sign8 = 0; x8 = 8'd12; y8 = 8'd11; vld8 = 1;
    @(posedge clk); #1;
    x8 = 8'd99;
    n = 0;
    while (!ovld8 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("bp vld", 64'(ovld8), 64'd1);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp res", 64'(res8), 64'h0084);
      check("bp rdy", 64'(ordy8), 64'd0);
      check("bp vld held", 64'(ovld8), 64'd1);
    end
    rdy8 = 1;
    @(posedge clk); #1;
    check("release vld", 64'(ovld8), 64'd0);
    check("release rdy", 64'(ordy8), 64'd1);
    @(posedge clk); #1;
    check("reaccept busy", 64'(busy8), 64'd1);
    check("reaccept rdy", 64'(ordy8), 64'd0);
    vld8 = 0;
    n = 0;
    while (q8.size() != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (q8.size() != 0) flag("bp drain");
    check("second res", 64'(res8), 64'd1089);

    // abort in CALC with counter at 2
    @(posedge clk); #1;
    sign8 = 0; x8 = 8'd200; y8 = 8'd7; vld8 = 1;
    @(posedge clk); #1;
    vld8 = 0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("abort vld", 64'(ovld8), 64'd0);
    check("abort rdy", 64'(ordy8), 64'd1);
    check("abort res", 64'(res8), 64'd0);
    check("abort busy", 64'(busy8), 64'd0);
    q8.delete();
    @(posedge clk); #1;
    rst_n = 1;
    run8(0, 8'd3, 8'd5);
    check("3x5", 64'(res8), 64'h000F);

    run16(1, 16'h8000, 16'h8000);
    check("ext signed", 64'(res16), 64'h40000000);
    run16(0, 16'hFFFF, 16'hFFFF);
    check("ext unsigned", 64'(res16), 64'hFFFE0001);
    for (int i = 0; i < 1000; i++)
      run16(1'($urandom), 16'($urandom), 16'($urandom));

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
